// File: rtl/n_channel_demux.sv
// ---------------------------------------------------------------------------
// n_channel_demux
//
// Streaming 1-to-N demultiplexer. A single valid/ready word stream is routed
// to one of N_OUTPUTS channel outputs. The channel is chosen once per packet:
// sel is sampled in IDLE when in_valid is seen, and it is held until the word
// carrying in_last has been accepted. An out-of-range sel sends the packet to
// DROP, where every word is accepted and thrown away.
//
// Each channel owns a one-entry holding register with its own valid/ready
// handshake. A channel can load and drain in the same cycle, so a consumer
// that is always ready sees one word per cycle.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   in_data        input word
//   in_valid       in_data valid
//   in_last        last word of packet (qualified by in_valid)
//   in_ready       block accepts the word this cycle
//   sel            target channel, sampled only in IDLE
//   out_data       channel i word at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   out_valid      per-channel word valid
//   out_last       per-channel last flag
//   out_ready      per-channel consumer ready
//   busy           high while a packet is in progress (state != IDLE)
//   sel_err        one-cycle pulse when an out-of-range sel is latched
//   sel_err_count  saturating count of out-of-range packets
// ---------------------------------------------------------------------------
module n_channel_demux #(
  parameter int N_OUTPUTS     = 8,
  parameter int DATA_WIDTH    = 22,
  parameter int SEL_WIDTH     = 5,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  input  logic [SEL_WIDTH-1:0]            sel,
  output logic [N_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [N_OUTPUTS-1:0]            out_valid,
  output logic [N_OUTPUTS-1:0]            out_last,
  input  logic [N_OUTPUTS-1:0]            out_ready,
  output logic                            busy,
  output logic                            sel_err,
  output logic [ERR_CNT_WIDTH-1:0]        sel_err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] N_OUT_U = N_OUTPUTS;

  state_t                     state_reg, state_next;
  logic [SEL_WIDTH-1:0]       cur_ch_reg, cur_ch_next;
  logic                       sel_err_reg, sel_err_next;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_reg, err_cnt_next;

  logic                       sel_in_range;
  logic                       in_fire;
  logic [N_OUTPUTS-1:0]       ch_hit;   // one-hot decode of cur_ch_reg
  logic [N_OUTPUTS-1:0]       ch_load;  // channel register loads this cycle

  // Zero-extend before comparing so any sel width works against N_OUTPUTS.
  assign sel_in_range = (32'(sel) < N_OUT_U);

  // ---------------------------------------------------------------------
  // Per-channel holding registers
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_OUTPUTS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  valid_reg;
      logic                  last_reg;

      // Decoding through a compare avoids indexing out_valid with a selector
      // that is wider than the channel count.
      assign ch_hit[gi]  = (cur_ch_reg == SEL_WIDTH'(gi));
      assign ch_load[gi] = in_fire & ch_hit[gi] & (state_reg == ROUTE);

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (ch_load[gi]) begin
          // A load wins over a simultaneous drain: the new word replaces
          // the one the consumer is taking this cycle.
          data_reg  <= in_data;
          last_reg  <= in_last;
          valid_reg <= 1'b1;
        end else if (valid_reg & out_ready[gi]) begin
          // Data is left in place after a drain; only valid drops.
          valid_reg <= 1'b0;
        end
      end

      assign out_data[DATA_WIDTH*gi +: DATA_WIDTH] = data_reg;
      assign out_valid[gi]                         = valid_reg;
      assign out_last[gi]                          = last_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      // Ready when the target register is empty or is draining this cycle.
      ROUTE:   in_ready = |(ch_hit & (~out_valid | out_ready));
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_fire = in_valid & in_ready;

  // ---------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cur_ch_reg  <= '0;
      sel_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_ch_reg  <= cur_ch_next;
      sel_err_reg <= sel_err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_ch_next  = cur_ch_reg;
    sel_err_next = 1'b0;
    err_cnt_next = err_cnt_reg;
    case (state_reg)
      IDLE: begin
        // Packet start costs one cycle: sel is latched, no word is taken.
        if (in_valid) begin
          cur_ch_next = sel;
          if (sel_in_range) begin
            state_next = ROUTE;
          end else begin
            state_next   = DROP;
            sel_err_next = 1'b1;
            if (err_cnt_reg != {ERR_CNT_WIDTH{1'b1}}) begin
              err_cnt_next = err_cnt_reg + ERR_CNT_WIDTH'(1);
            end
          end
        end
      end
      ROUTE, DROP: begin
        if (in_fire & in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state_reg != IDLE);
  assign sel_err       = sel_err_reg;
  assign sel_err_count = err_cnt_reg;

endmodule

// File: tb/tb_n_channel_demux.sv
// ---------------------------------------------------------------------------
// tb_n_channel_demux
//
// Self-checking bench for n_channel_demux. A second instance built with a
// 2-bit error counter shares all inputs and is used for counter saturation.
// A cycle-level reference model, written directly from the packet rules,
// is compared against both instances on every falling edge; directed
// vectors and sequences add targeted checks on top.
// ---------------------------------------------------------------------------
module tb_n_channel_demux;

  localparam int N  = 8;
  localparam int DW = 22;
  localparam int SW = 5;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_last;
  logic [SW-1:0]     sel;
  logic [N-1:0]      out_ready;

  logic              in_ready,  s_in_ready;
  logic [N*DW-1:0]   out_data,  s_out_data;
  logic [N-1:0]      out_valid, s_out_valid;
  logic [N-1:0]      out_last,  s_out_last;
  logic              busy,      s_busy;
  logic              sel_err,   s_sel_err;
  logic [CW-1:0]     sel_err_count;
  logic [1:0]        s_sel_err_count;

  always #5 clk = ~clk;

  n_channel_demux #(.N_OUTPUTS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .ERR_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .sel_err(sel_err),
    .sel_err_count(sel_err_count)
  );

  n_channel_demux #(.N_OUTPUTS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .sel(sel), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_last(s_out_last), .out_ready(out_ready), .busy(s_busy), .sel_err(s_sel_err),
    .sel_err_count(s_sel_err_count)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: mode 0 = waiting for packet, 1 = routing, 2 = dropping
  // ---------------------------------------------------------------------
  int            m_mode = 0;
  int            m_ch   = 0;
  logic [N-1:0]  m_v    = '0;
  logic [N-1:0]  m_l    = '0;
  logic [DW-1:0] m_d [N];
  logic          m_err  = 1'b0;
  int            m_cnt  = 0;

  initial for (int i = 0; i < N; i++) m_d[i] = '0;

  always @(negedge clk) begin : model_check
    logic e_ir;
    if (chk_en) begin
      e_ir = 1'b0;
      if (m_mode == 1)      e_ir = !m_v[m_ch] || out_ready[m_ch];
      else if (m_mode == 2) e_ir = 1'b1;

      chk("m_in_ready", 64'(in_ready), 64'(e_ir));
      chk("m_busy", 64'(busy), 64'(m_mode != 0));
      chk("m_out_valid", 64'(out_valid), 64'(m_v));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("m_out_data%0d", i), 64'(out_data[i*DW +: DW]), 64'(m_d[i]));
        if (m_v[i]) chk($sformatf("m_out_last%0d", i), 64'(out_last[i]), 64'(m_l[i]));
      end
      chk("m_sel_err", 64'(sel_err), 64'(m_err));
      chk("m_err_count", 64'(sel_err_count), 64'(m_cnt));
      chk("m_sat_out_valid", 64'(s_out_valid), 64'(m_v));
      chk("m_sat_sel_err", 64'(s_sel_err), 64'(m_err));
      chk("m_sat_err_count", 64'(s_sel_err_count), 64'((m_cnt > 3) ? 3 : m_cnt));

      // Advance the model across the coming rising edge.
      if (rst) begin
        m_mode = 0; m_ch = 0; m_v = '0; m_l = '0; m_err = 1'b0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_d[i] = '0;
      end else begin
        m_v   = m_v & ~out_ready;
        m_err = 1'b0;
        case (m_mode)
          0: if (in_valid) begin
               m_ch = int'(sel);
               if (m_ch < N) m_mode = 1;
               else begin
                 m_mode = 2; m_err = 1'b1;
                 if (m_cnt < (1 << CW) - 1) m_cnt++;
               end
             end
          1: if (in_valid && e_ir) begin
               m_v[m_ch] = 1'b1; m_d[m_ch] = in_data; m_l[m_ch] = in_last;
               if (in_last) m_mode = 0;
             end
          default: if (in_valid && e_ir && in_last) m_mode = 0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic l, input logic [SW-1:0] s,
                       input logic [DW-1:0] d, input logic [N-1:0] r);
    in_valid = v; in_last = l; sel = s; in_data = d; out_ready = r;
  endtask

  typedef struct {
    logic          iv, il;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    logic [N-1:0]  r;
    logic          e_ir, e_busy;
    logic [N-1:0]  e_ov;
    logic [DW-1:0] e_d2;
    logic          e_l2;
  } vec_t;

  vec_t tbl [6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DW-1:0] got [$];
    int acc_cnt, first_acc, c;

    // 3-word packet to channel 2, consumer always ready.
    tbl[0] = '{1'b1, 1'b0, 5'd2, 22'h1, 8'hFF, 1'b0, 1'b0, 8'h00, 22'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 5'd2, 22'h1, 8'hFF, 1'b1, 1'b1, 8'h00, 22'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd2, 22'h2, 8'hFF, 1'b1, 1'b1, 8'h04, 22'h1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 5'd2, 22'h3, 8'hFF, 1'b1, 1'b1, 8'h04, 22'h2, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 5'd2, 22'h0, 8'hFF, 1'b0, 1'b0, 8'h04, 22'h3, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 5'd2, 22'h0, 8'hFF, 1'b0, 1'b0, 8'h00, 22'h3, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_err_count", 64'(sel_err_count), 64'h0);
    tick();

    // Table-driven basic packet.
    for (int k = 0; k < 6; k++) begin
      drive(tbl[k].iv, tbl[k].il, tbl[k].s, tbl[k].d, tbl[k].r);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_data2", k), 64'(out_data[2*DW +: DW]), 64'(tbl[k].e_d2));
      if (tbl[k].e_ov[2]) chk($sformatf("tbl%0d_last2", k), 64'(out_last[2]), 64'(tbl[k].e_l2));
      tick();
    end

    // Backpressure: channel 5 consumer stalls for 5 cycles after word 1.
    acc_cnt = 0; first_acc = -1; c = 0;
    while ((acc_cnt < 4 || out_valid[5]) && c < 60) begin
      logic [N-1:0] r;
      logic in_win;
      in_win = (first_acc >= 0) && (c > first_acc) && (c <= first_acc + 5);
      r = 8'hFF;
      if (in_win) r[5] = 1'b0;
      drive(acc_cnt < 4, acc_cnt == 3, 5'd5, DW'(acc_cnt + 1), r);
      @(negedge clk);
      if (in_win) chk("bp_ready_low", 64'(in_ready), 64'h0);
      if (first_acc >= 0 && c == first_acc + 6) chk("bp_ready_rise", 64'(in_ready), 64'h1);
      if (out_valid[5] && out_ready[5]) got.push_back(out_data[5*DW +: DW]);
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = c;
        acc_cnt++;
      end
      tick();
      c++;
    end
    chk("bp_no_timeout", 64'(c < 60), 64'h1);
    chk("bp_word_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < got.size() && k < 4; k++)
      chk($sformatf("bp_word%0d", k), 64'(got[k]), 64'(k + 1));
    drive(1'b0, 1'b0, '0, '0, 8'hFF);
    tick();

    // Out-of-range select, 2-word packet.
    drive(1'b1, 1'b0, 5'd9, 22'h0AA, 8'hFF);
    @(negedge clk); chk("oor_err_idle", 64'(sel_err), 64'h0); tick();
    @(negedge clk);
    chk("oor_err_pulse", 64'(sel_err), 64'h1);
    chk("oor_count", 64'(sel_err_count), 64'h1);
    chk("oor_ready", 64'(in_ready), 64'h1);
    tick();
    drive(1'b1, 1'b1, 5'd9, 22'h0BB, 8'hFF);
    @(negedge clk); chk("oor_err_once", 64'(sel_err), 64'h0); tick();
    drive(1'b0, 1'b0, 5'd9, '0, 8'hFF);
    @(negedge clk);
    chk("oor_back_idle", 64'(busy), 64'h0);
    chk("oor_no_valid", 64'(out_valid), 64'h0);
    chk("oor_count_hold", 64'(sel_err_count), 64'h1);
    tick();

    // Select changes mid-packet are ignored.
    drive(1'b1, 1'b0, 5'd1, 22'h11, 8'hFF); @(negedge clk); tick();
    drive(1'b1, 1'b0, 5'd1, 22'h11, 8'hFF); @(negedge clk); tick();
    drive(1'b1, 1'b0, 5'd6, 22'h12, 8'hFF); @(negedge clk); tick();
    drive(1'b1, 1'b1, 5'd6, 22'h13, 8'hFF); @(negedge clk); tick();
    drive(1'b0, 1'b0, 5'd6, '0, 8'hFF);
    @(negedge clk);
    chk("selchg_valid", 64'(out_valid), 64'h02);
    chk("selchg_ch1_data", 64'(out_data[1*DW +: DW]), 64'h13);
    chk("selchg_ch6_data", 64'(out_data[6*DW +: DW]), 64'h0);
    tick();

    // Reset mid-packet with channel 3 full.
    drive(1'b1, 1'b0, 5'd3, 22'h31, 8'hF7); @(negedge clk); tick();
    drive(1'b1, 1'b0, 5'd3, 22'h31, 8'hF7); @(negedge clk); tick();
    drive(1'b1, 1'b0, 5'd3, 22'h32, 8'hF7);
    @(negedge clk);
    chk("rstmid_ch3_full", 64'(out_valid[3]), 64'h1);
    chk("rstmid_stalled", 64'(in_ready), 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 22'h41, 8'hFF);
    @(negedge clk);
    chk("rstmid_valid0", 64'(out_valid), 64'h0);
    chk("rstmid_data0", 64'(out_data == '0), 64'h1);
    chk("rstmid_idle", 64'(busy), 64'h0);
    tick();
    @(negedge clk);
    chk("rstmid_new_pkt_ready", 64'(in_ready), 64'h1);
    tick();
    drive(1'b0, 1'b0, 5'd4, '0, 8'hFF);
    @(negedge clk);
    chk("rstmid_ch4_valid", 64'(out_valid), 64'h10);
    chk("rstmid_ch4_data", 64'(out_data[4*DW +: DW]), 64'h41);
    tick();

    // Randomised traffic checked by the model, with rare resets.
    for (int k = 0; k < 2500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_last   = ($urandom_range(0, 9) < 3);
      sel       = SW'($urandom_range(0, 9));
      in_data   = DW'($urandom);
      for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;

    // Saturation of the 2-bit counter.
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 8'hFF);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b1, 5'd9, DW'(k), 8'hFF);
      @(negedge clk); chk("sat_err_idle", 64'(s_sel_err), 64'h0); tick();
      @(negedge clk);
      chk($sformatf("sat_pulse%0d", k), 64'(s_sel_err), 64'h1);
      chk($sformatf("sat_count%0d", k), 64'(s_sel_err_count), 64'((k > 3) ? 3 : k));
      chk($sformatf("wide_count%0d", k), 64'(sel_err_count), 64'(k));
      tick();
      drive(1'b0, 1'b0, 5'd9, '0, 8'hFF);
      @(negedge clk); chk("sat_err_off", 64'(s_sel_err), 64'h0); tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n_channel_demux.md
Name: n_channel_demux

Overview:
Streaming 1-to-N demultiplexer. It is the distribution counterpart of the N-channel mux: it routes a single valid/ready word stream to one of N channel outputs. The channel is selected once per packet; sel is latched at packet start and held until in_last. Each channel output has a one-entry registered holding stage with its own valid/ready handshake. The block sits between a shared data source (e.g. the config/readout word stream) and per-channel consumers.

Parameters:
N_OUTPUTS, 8, number of output channels
DATA_WIDTH, 22, width of one data word
SEL_WIDTH, 5, width of the channel selector
ERR_CNT_WIDTH, 16, width of the saturating bad-select counter

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
in_data  input  DATA_WIDTH  input word
in_valid  input  1  in_data valid
in_last  input  1  word is last of packet; qualified by in_valid
in_ready  output  1  block accepts word this cycle
sel  input  SEL_WIDTH  target channel; sampled only in IDLE
out_data  output  N_OUTPUTS*DATA_WIDTH  channel i word at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
out_valid  output  N_OUTPUTS  per-channel word valid
out_last  output  N_OUTPUTS  per-channel last flag; meaningful when out_valid[i]
out_ready  input  N_OUTPUTS  per-channel consumer ready
busy  output  1  high while not in IDLE
sel_err  output  1  one-cycle pulse when an out-of-range sel is latched
sel_err_count  output  ERR_CNT_WIDTH  count of out-of-range packets; saturates at all-ones

Behaviour:
- Transfer rules: an input transfer occurs when in_valid & in_ready. A channel transfer occurs when out_valid[i] & out_ready[i].
- Reset (rst high at a clock edge) forces:
  - state = IDLE
  - out_data, out_valid, out_last = 0
  - in_ready = 0, busy = 0, sel_err = 0, sel_err_count = 0
  - latched channel = 0
- Reset wins over every other event in that cycle. Reset mid-packet discards the holding registers. After reset, the next in_valid word is treated as a packet start.
- FSM states: IDLE, ROUTE, DROP.
- IDLE:
  - in_ready = 0.
  - When in_valid = 1, latch sel into cur_ch.
  - If sel < N_OUTPUTS, go to ROUTE.
  - Otherwise go to DROP. Pulse sel_err for exactly one cycle, and increment sel_err_count unless it is saturated.
  - No word is consumed in IDLE; packet start costs exactly one cycle.
- ROUTE:
  - in_ready = ~out_valid[cur_ch] | out_ready[cur_ch]. This allows a full-throughput pass-through when the consumer drains in the same cycle.
  - On an input transfer, the holding register of cur_ch loads in_data and in_last, and out_valid[cur_ch] is set. The word appears on the outputs the cycle after acceptance (latency 1).
  - On an input transfer with in_last = 1, go to IDLE.
  - Changes on sel during ROUTE are ignored.
- DROP:
  - in_ready = 1. Words are discarded and no output changes.
  - On an input transfer with in_last = 1, go to IDLE.
- Channel registers (all channels, every cycle):
  - A channel transfer with no simultaneous load clears out_valid[i].
  - A simultaneous load and channel transfer leaves out_valid[i] = 1 with the new word.
  - out_data[i] holds its last value after a drain; it is never zeroed except by reset.
  - Non-selected channels continue to drain independently while another channel is being routed.
- A single-word packet (in_last on the first word) goes IDLE -> ROUTE -> IDLE and occupies 2 cycles minimum.
- Back-to-back packets have one IDLE cycle between them. A new packet may target a channel whose register is still full; in_ready stays low until that register drains.
- busy = (state != IDLE).

Test Plan:
- Reset then 3-word packet: sel=2, data 0x00001,0x00002,0x00003 (last on third), all out_ready=1 -> out_valid[2] high for 3 consecutive cycles starting 2 cycles after in_valid rises; out_last[2] on the third word; other out_valid stay 0; in_ready high exactly 3 cycles.
- Backpressure: sel=5, 4-word packet, out_ready[5] low for 5 cycles after the first word -> in_ready low while the register is full; no word lost or duplicated; order 1..4 preserved; second word issues the cycle out_ready[5] rises.
- Out-of-range select: sel=9 with N_OUTPUTS=8, 2-word packet -> sel_err pulses once, sel_err_count=1, all out_valid remain 0, block back in IDLE after the last word.
- Select change mid-packet: sel=1 at start, switched to 6 after the first word -> all words go to channel 1; channel 6 untouched.
- Reset mid-packet: assert rst for 1 cycle during word 2 of a sel=3 packet with out_valid[3]=1 -> all outputs 0 the next cycle, state IDLE; the next in_valid is latched as a fresh packet start using the current sel.
- Saturation: force 2^ERR_CNT_WIDTH+2 bad-select packets (use ERR_CNT_WIDTH=2 build) -> sel_err_count stops at 3 while sel_err still pulses each packet.
